// File: rtl/alu_seq_fsm.sv
// Sequencer for a bus-based ALU datapath: drives two operands onto the bus,
// runs the ALU, and writes the result back into the destination register.
module alu_seq_fsm #(
    parameter int INSTR_W    = 16,
    parameter int SEL_W      = 6,
    parameter int NREG       = 6,
    parameter int ALU_OP_MIN = 9,
    parameter int SETTLE     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               abort,
    output logic [NREG-1:0]    reg_out_en,
    output logic [NREG-1:0]    reg_in_en,
    output logic               pc_inc,
    output logic               alu_in1,
    output logic               alu_in2,
    output logic               alu_out_latch,
    output logic               alu_out_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int P1_LO = INSTR_W - 4 - SEL_W;
    localparam int P2_LO = P1_LO - SEL_W;
    localparam int NW    = SEL_W + 1;

    localparam logic [3:0]    OP_MIN = 4'(ALU_OP_MIN);
    localparam logic [3:0]    SET_V  = 4'(SETTLE);
    localparam logic [NW-1:0] NREG_V = NW'(NREG);

    typedef enum logic [3:0] {
        IDLE, S1_DRV, S1_LAT, S2_DRV, S2_LAT,
        EXEC, WB_DRV, WB_LAT, DONE, ERR
    } state_t;

    state_t           state, nxt;
    logic [3:0]       cnt;
    logic [SEL_W-1:0] p1, p2;

    logic [3:0]       op_live;
    logic [SEL_W-1:0] p1_live, p2_live;
    logic             accept, legal, last_exec;

    assign op_live   = instr[INSTR_W-1 -: 4];
    assign p1_live   = instr[P1_LO +: SEL_W];
    assign p2_live   = instr[P2_LO +: SEL_W];
    assign accept    = start && (op_live >= OP_MIN);
    assign legal     = ({1'b0, p1_live} < NREG_V) && ({1'b0, p2_live} < NREG_V);
    assign last_exec = (cnt == SET_V);

    function automatic logic [NREG-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = (s == SEL_W'(i));
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            p1    <= '0;
            p2    <= '0;
        end else begin
            state <= nxt;
            if (state == EXEC && nxt == EXEC) cnt <= cnt + 4'd1;
            else                              cnt <= '0;
            // Operand selects are frozen for the whole instruction
            if (state == IDLE && nxt != IDLE) begin
                p1 <= p1_live;
                p2 <= p2_live;
            end
        end
    end

    always_comb begin
        nxt           = state;
        reg_out_en    = '0;
        reg_in_en     = '0;
        pc_inc        = 1'b0;
        alu_in1       = 1'b0;
        alu_in2       = 1'b0;
        alu_out_latch = 1'b0;
        alu_out_en    = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        busy          = (state != IDLE);
        unique case (state)
            IDLE: if (accept) nxt = legal ? S1_DRV : ERR;
            S1_DRV: begin
                reg_out_en = onehot(p1);
                pc_inc     = 1'b1;
                nxt        = S1_LAT;
            end
            S1_LAT: begin
                reg_out_en = onehot(p1);
                alu_in1    = 1'b1;
                nxt        = S2_DRV;
            end
            S2_DRV: begin
                reg_out_en = onehot(p2);
                nxt        = S2_LAT;
            end
            S2_LAT: begin
                reg_out_en = onehot(p2);
                alu_in2    = 1'b1;
                nxt        = EXEC;
            end
            EXEC: begin
                alu_out_latch = last_exec;
                if (last_exec) nxt = WB_DRV;
            end
            WB_DRV: begin
                alu_out_en = 1'b1;
                nxt        = WB_LAT;
            end
            WB_LAT: begin
                alu_out_en = 1'b1;
                reg_in_en  = onehot(p1);
                nxt        = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            ERR: begin
                err = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Bench for alu_seq_fsm: two instances (SETTLE 0 and 3) checked every cycle
// against a cycle-position reference model of the instruction timeline.
module tb_alu_seq_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort;
    logic [15:0] instr;

    logic [5:0] roe0, rie0, roe1, rie1;
    logic pc0, i10, i20, lat0, oen0, bsy0, dn0, er0;
    logic pc1, i11, i21, lat1, oen1, bsy1, dn1, er1;
    logic [19:0] obs0, obs1;

    assign obs0 = {roe0, rie0, pc0, i10, i20, lat0, oen0, bsy0, dn0, er0};
    assign obs1 = {roe1, rie1, pc1, i11, i21, lat1, oen1, bsy1, dn1, er1};

    alu_seq_fsm #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .abort(abort),
        .reg_out_en(roe0), .reg_in_en(rie0), .pc_inc(pc0), .alu_in1(i10),
        .alu_in2(i20), .alu_out_latch(lat0), .alu_out_en(oen0),
        .busy(bsy0), .done(dn0), .err(er0)
    );

    alu_seq_fsm #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .abort(abort),
        .reg_out_en(roe1), .reg_in_en(rie1), .pc_inc(pc1), .alu_in1(i11),
        .alu_in2(i21), .alu_out_latch(lat1), .alu_out_en(oen1),
        .busy(bsy1), .done(dn1), .err(er1)
    );

    int total = 0;
    int bad   = 0;

    // Model state: cycles since acceptance (0 = idle) and accepted word
    int          pos [2];
    logic [15:0] li  [2];
    int          st  [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ok(input logic [15:0] w);
        return (int'(w[11:6]) < 6) && (int'(w[5:0]) < 6);
    endfunction

    function automatic int mlen(input int s, input logic [15:0] w);
        return ok(w) ? 8 + s : 1;
    endfunction

    function automatic logic [19:0] pk(
        input logic [5:0] oe, input logic [5:0] ie, input logic pc,
        input logic a1, input logic a2, input logic lt, input logic ao,
        input logic dn, input logic er);
        return {oe, ie, pc, a1, a2, lt, ao, 1'b1, dn, er};
    endfunction

    function automatic logic [19:0] expv(input int s, input logic [15:0] w,
                                         input int p);
        logic [5:0] o1, o2;
        o1 = 6'd1 << w[11:6];
        o2 = 6'd1 << w[5:0];
        if (p == 0) return '0;
        if (!ok(w)) return pk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        if (p == 1) return pk(o1, 0, 1, 0, 0, 0, 0, 0, 0);
        if (p == 2) return pk(o1, 0, 0, 1, 0, 0, 0, 0, 0);
        if (p == 3) return pk(o2, 0, 0, 0, 0, 0, 0, 0, 0);
        if (p == 4) return pk(o2, 0, 0, 0, 1, 0, 0, 0, 0);
        if (p <= 5 + s) return pk(0, 0, 0, 0, 0, p == 5 + s, 0, 0, 0);
        if (p == 6 + s) return pk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (p == 7 + s) return pk(0, o1, 0, 0, 0, 0, 1, 0, 0);
        return pk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    endfunction

    task automatic cyc(input logic r, input logic s, input logic [15:0] w,
                       input logic a);
        @(negedge clk);
        rst   = r;
        start = s;
        instr = w;
        abort = a;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!r || a) pos[k] = 0;
            else if (pos[k] == 0) begin
                if (s && w[15:12] >= 4'd9) begin
                    pos[k] = 1;
                    li[k]  = w;
                end
            end else if (pos[k] == mlen(st[k], li[k])) pos[k] = 0;
            else pos[k] = pos[k] + 1;
        end
        #1;
        chk("s0_outs", {12'b0, obs0}, {12'b0, expv(st[0], li[0], pos[0])});
        chk("s3_outs", {12'b0, obs1}, {12'b0, expv(st[1], li[1], pos[1])});
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        instr = '0;
        pos   = '{0, 0};
        li    = '{16'h0, 16'h0};
        st    = '{0, 3};

        repeat (2) cyc(0, 0, 16'h0, 0);
        chk("reset_idle", {12'b0, obs0 | obs1}, 32'h0);

        cyc(1, 1, 16'h9042, 0);
        repeat (13) cyc(1, 0, 16'h0, 0);

        cyc(1, 1, 16'h9FC2, 0);
        repeat (4) cyc(1, 0, 16'h0, 0);

        repeat (10) cyc(1, 1, 16'h1042, 0);

        cyc(1, 1, 16'h9041, 0);
        repeat (13) cyc(1, 0, 16'h0, 0);

        cyc(1, 1, 16'h9042, 0);
        repeat (4) cyc(1, 0, 16'h0, 0);
        cyc(1, 0, 16'h0, 1);
        cyc(1, 1, 16'h9085, 0);
        repeat (13) cyc(1, 0, 16'h0, 0);

        cyc(1, 1, 16'h9042, 0);
        repeat (5) cyc(1, 1, 16'h9042, 0);
        repeat (3) cyc(0, 1, 16'h9042, 0);
        repeat (14) cyc(1, 1, 16'h9042, 0);
        cyc(1, 0, 16'h0, 0);
        repeat (12) cyc(1, 0, 16'h0, 0);

        for (int n = 0; n < 3000; n++) begin
            logic       r, s, a;
            logic [3:0] op;
            logic [5:0] q1, q2;
            r  = ($urandom_range(0, 79) != 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 39) == 0);
            op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(9, 15))
                                             : 4'($urandom_range(0, 15));
            q1 = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(0, 5));
            q2 = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(0, 5));
            cyc(r, s, {op, q1, q2}, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_fsm.md
ALU_SEQ_FSM -- requirements
Module: alu_seq_fsm

Parameters
REQ-001 SHALL provide INSTR_W, default 16: instruction word width.
REQ-002 SHALL provide SEL_W, default 6: register-select field width.
REQ-003 SHALL provide NREG, default 6, range 2..2^SEL_W: number of bus registers, one-hot indexed.
REQ-004 SHALL provide ALU_OP_MIN, default 9: lowest opcode treated as an ALU operation.
REQ-005 SHALL provide SETTLE, default 0, range 0..15: extra ALU compute cycles after EXEC.

Interface
REQ-006 SHALL have: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have: rst  in  1  synchronous, active-low reset.
REQ-008 SHALL have: start  in  1  request to run the instruction on instr.
REQ-009 SHALL have: instr  in  INSTR_W  opcode in the top 4 bits; then param1 (SEL_W, destination and source A); then param2 (SEL_W, source B).
REQ-010 SHALL have: abort  in  1  fetch-active cancel.
REQ-011 SHALL have: reg_out_en  out  NREG  one-hot register drive-to-bus enable.
REQ-012 SHALL have: reg_in_en  out  NREG  one-hot register load-from-bus enable.
REQ-013 SHALL have: pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en  out  1 each  datapath strobes.
REQ-014 SHALL have: busy  out  1 (high when not IDLE); done  out  1; err  out  1.

Function
REQ-015 SHALL use states IDLE, S1_DRV, S1_LAT, S2_DRV, S2_LAT, EXEC, WB_DRV, WB_LAT, DONE, ERR.
REQ-016 In IDLE, start high with opcode >= ALU_OP_MIN SHALL latch instr internally; the FSM ignores live instr until it next returns to IDLE.
REQ-017 In IDLE, start with opcode < ALU_OP_MIN SHALL be ignored; the FSM stays in IDLE with no output activity.
REQ-018 On an accepted start with param1 >= NREG or param2 >= NREG, the next state SHALL be ERR, not S1_DRV.
REQ-019 ERR SHALL assert err for one cycle, then return to IDLE; no pc_inc, no reg_in_en.
REQ-020 Transitions SHALL be S1_DRV->S1_LAT->S2_DRV->S2_LAT->EXEC->WB_DRV->WB_LAT->DONE->IDLE, one cycle each.
REQ-021 Exception to REQ-020: EXEC SHALL last 1+SETTLE cycles, timed by an internal counter.
REQ-022 S1_DRV: reg_out_en[param1]=1 and pc_inc=1 (single cycle).
REQ-023 S1_LAT: reg_out_en[param1]=1 and alu_in1=1.
REQ-024 S2_DRV: reg_out_en[param2]=1.
REQ-025 S2_LAT: reg_out_en[param2]=1 and alu_in2=1.
REQ-026 EXEC: alu_out_latch=1 on the final EXEC cycle only; all other outputs 0.
REQ-027 WB_DRV: alu_out_en=1.
REQ-028 WB_LAT: alu_out_en=1 and reg_in_en[param1]=1.
REQ-029 DONE: done=1 for exactly one cycle.
REQ-030 Any output not listed for a state SHALL be 0.
REQ-031 reg_out_en and reg_in_en SHALL be one-hot or zero at all times, never both nonzero in the same cycle.
REQ-032 All outputs SHALL depend only on state, the EXEC counter and latched instr, never on live inputs.
REQ-033 Latency: with start accepted at edge 0, done SHALL be high in cycle 8+SETTLE.
REQ-034 start while busy SHALL be ignored; it is not queued.
REQ-035 start sampled in the DONE cycle SHALL also be ignored.
REQ-036 abort high in any state SHALL force IDLE at the next edge with all outputs 0 and no done/err.
REQ-037 abort SHALL take priority over start and over the ERR path.
REQ-038 param1 == param2 SHALL be legal; the same register is driven in both operand phases.

Reset
REQ-039 rst low at a clock edge SHALL force IDLE and clear the EXEC counter and latched instr.
REQ-040 After reset, all outputs (reg_out_en, reg_in_en, strobes, busy, done, err) SHALL be 0.
REQ-041 Reset SHALL override abort and start, including mid-operation.

Verification
REQ-042 NREG=6, SETTLE=0, start with instr=0x9042 -> pc_inc in cycle 1; reg_out_en=000010 in cycles 1-2; reg_out_en=000100 in cycles 3-4; alu_out_latch in cycle 5; reg_in_en=000010 in cycle 7; done in cycle 8.
REQ-043 SETTLE=3, instr=0x9042 -> EXEC spans cycles 5-8, alu_out_latch in cycle 8 only, done in cycle 11.
REQ-044 instr=0x9FC2 (param1=63) -> err in cycle 1; no pc_inc or reg_in_en ever; busy low from cycle 2.
REQ-045 instr=0x1042 with start high -> FSM stays in IDLE; all outputs 0 for 10 cycles.
REQ-046 abort asserted during EXEC -> IDLE next cycle; reg_in_en never asserted; a new start then completes normally.
REQ-047 rst low in WB_DRV -> all outputs 0 next cycle; start held high throughout is ignored until rst returns high.
